// File: rtl/ttl_mux_scanner.sv
// ttl_mux_scanner: registered CHANNELS x WIDTH:1 mux with direct select or an internal dwell-timed scan sequencer.
// Optional complementary outputs w_n (74x151 style) are enabled by defining TTL_MUX_SCANNER_WN_EN.
module ttl_mux_scanner #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DWELL    = 1,
  localparam int SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic                      scan,
  input  logic [CHANNELS*WIDTH-1:0] c,
  input  logic [CHANNELS-1:0]       g_n,
  output logic [CHANNELS-1:0]       y,
  output logic [SEL_WIDTH-1:0]      sel_q,
  output logic                      wrap
`ifdef TTL_MUX_SCANNER_WN_EN
  ,
  output logic [CHANNELS-1:0]       w_n
`endif
);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  typedef enum logic {DIRECT, SCANNING} state_t;
  state_t               state;
  logic [SEL_WIDTH-1:0] pos;
  logic [DW-1:0]        dwell;
  logic [SEL_WIDTH-1:0] s;
  logic [CHANNELS-1:0]  y_d;
  logic                 pos_last;
  logic                 dwell_last;
  assign s          = (state == SCANNING) ? pos : sel;
  assign pos_last   = pos == SEL_WIDTH'(WIDTH - 1);
  assign dwell_last = dwell == DW'(DWELL - 1);
  // An out-of-range select shifts the one-hot mask off the end, so it reads as 0.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign y_d[k] = ~g_n[k] & |(c[k*WIDTH +: WIDTH] & (WIDTH'(1) << s));
  end
  // Sample the mux and advance the direct/scan sequencer on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIRECT;
      pos   <= '0;
      dwell <= '0;
      y     <= '0;
      sel_q <= '0;
      wrap  <= 1'b0;
    end else begin
      y     <= y_d;
      sel_q <= s;
      wrap  <= 1'b0;
      if (state == DIRECT) begin
        if (scan) begin
          state <= SCANNING;
          pos   <= '0;
          dwell <= '0;
        end
      end else if (!scan) begin
        state <= DIRECT;
        pos   <= '0;
        dwell <= '0;
      end else if (dwell_last) begin
        dwell <= '0;
        pos   <= pos_last ? '0 : pos + 1'b1;
        wrap  <= pos_last;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end
`ifdef TTL_MUX_SCANNER_WN_EN
  assign w_n = ~y;
`endif
endmodule

// File: tb/tb_ttl_mux_scanner.sv
// tb_ttl_mux_scanner: table vectors and scan sequences checked through an expectation queue.
module tb_ttl_mux_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n;
  logic [1:0] sel4;
  logic       scan4;
  logic [7:0] c4;
  logic [1:0] g4, y4, sq4;
  logic       wr4;
  logic [2:0] sel5, sq5;
  logic       scan5;
  logic [9:0] c5;
  logic [1:0] g5, y5;
  logic       wr5;
`ifdef TTL_MUX_SCANNER_WN_EN
  logic [1:0] wn4, wn5;
`endif
  ttl_mux_scanner #(.WIDTH(4), .CHANNELS(2), .DWELL(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sel(sel4), .scan(scan4), .c(c4), .g_n(g4),
    .y(y4), .sel_q(sq4), .wrap(wr4)
`ifdef TTL_MUX_SCANNER_WN_EN
    , .w_n(wn4)
`endif
  );
  ttl_mux_scanner #(.WIDTH(5), .CHANNELS(2), .DWELL(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .sel(sel5), .scan(scan5), .c(c5), .g_n(g5),
    .y(y5), .sel_q(sq5), .wrap(wr5)
`ifdef TTL_MUX_SCANNER_WN_EN
    , .w_n(wn5)
`endif
  );
  typedef struct {
    logic       d5;
    logic [1:0] y;
    logic [2:0] sq;
    logic       wr;
    string      name;
  } exp_t;
  typedef struct {
    logic [1:0] sel;
    logic [1:0] g;
    logic [1:0] y;
  } vec_t;
  exp_t sb[$];
  vec_t vt[12];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [4:0] ch0 = 5'b10110;
  logic [4:0] ch1 = 5'b01001;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (e.d5) begin
      cmp({e.name, ".y"}, 32'(y5), 32'(e.y));
      cmp({e.name, ".sel_q"}, 32'(sq5), 32'(e.sq));
      cmp({e.name, ".wrap"}, 32'(wr5), 32'(e.wr));
`ifdef TTL_MUX_SCANNER_WN_EN
      cmp({e.name, ".w_n"}, 32'(wn5), 32'(~e.y));
`endif
    end else begin
      cmp({e.name, ".y"}, 32'(y4), 32'(e.y));
      cmp({e.name, ".sel_q"}, 32'(sq4), 32'(e.sq));
      cmp({e.name, ".wrap"}, 32'(wr4), 32'(e.wr));
`ifdef TTL_MUX_SCANNER_WN_EN
      cmp({e.name, ".w_n"}, 32'(wn4), 32'(~e.y));
`endif
    end
  endtask
  task automatic expect_now(input logic d5, input logic [1:0] y, input logic [2:0] sq, input logic wr, input string name);
    sb.push_back('{d5, y, sq, wr, name});
    check();
  endtask
  task automatic tick(input logic d5, input logic [1:0] y, input logic [2:0] sq, input logic wr, input string name);
    sb.push_back('{d5, y, sq, wr, name});
    @(posedge clk);
    #1;
    check();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0]  = '{2'd0, 2'b00, 2'b01};
    vt[1]  = '{2'd1, 2'b00, 2'b10};
    vt[2]  = '{2'd2, 2'b00, 2'b01};
    vt[3]  = '{2'd3, 2'b00, 2'b10};
    vt[4]  = '{2'd0, 2'b01, 2'b00};
    vt[5]  = '{2'd1, 2'b01, 2'b10};
    vt[6]  = '{2'd2, 2'b01, 2'b00};
    vt[7]  = '{2'd3, 2'b01, 2'b10};
    vt[8]  = '{2'd0, 2'b10, 2'b01};
    vt[9]  = '{2'd1, 2'b10, 2'b00};
    vt[10] = '{2'd2, 2'b11, 2'b00};
    vt[11] = '{2'd3, 2'b11, 2'b00};
    rst_n = 1'b0;
    scan4 = 1'b1; scan5 = 1'b1;
    sel4 = '0; sel5 = '0; c4 = '0; c5 = '0; g4 = '0; g5 = '0;
    #1;
    expect_now(1'b0, 2'b00, 3'd0, 1'b0, "reset4");
    expect_now(1'b1, 2'b00, 3'd0, 1'b0, "reset5");
    for (int i = 0; i < 4; i++) begin
      c4 = 8'($urandom);
      c5 = 10'($urandom);
      tick(1'b0, 2'b00, 3'd0, 1'b0, "reset_hold");
    end
    expect_now(1'b1, 2'b00, 3'd0, 1'b0, "reset_hold5");
    scan4 = 1'b0; scan5 = 1'b0; sel4 = 2'd2; c4 = 8'h04; g4 = 2'b00;
    rst_n = 1'b1;
    tick(1'b0, 2'b01, 3'd2, 1'b0, "reset_release");
    c4 = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      sel4 = vt[i].sel;
      g4   = vt[i].g;
      tick(1'b0, vt[i].y, 3'(vt[i].sel), 1'b0, $sformatf("direct%0d", i));
    end
    g4 = 2'b00; sel4 = 2'd2; scan4 = 1'b1;
    tick(1'b0, 2'b01, 3'd2, 1'b0, "scan_entry");
    for (int i = 0; i < 10; i++)
      tick(1'b0, (i % 2 == 1) ? 2'b10 : 2'b01, 3'(i % 4), i % 4 == 3, $sformatf("scan4_%0d", i));
    scan4 = 1'b0; sel4 = 2'd1;
    tick(1'b0, 2'b01, 3'd2, 1'b0, "scan_exit");
    tick(1'b0, 2'b10, 3'd1, 1'b0, "direct_after_exit");
    scan4 = 1'b1;
    tick(1'b0, 2'b10, 3'd1, 1'b0, "reentry_sel");
    tick(1'b0, 2'b01, 3'd0, 1'b0, "reentry_pos0");
    tick(1'b0, 2'b10, 3'd1, 1'b0, "reentry_pos1");
    scan4 = 1'b0;
    c5 = {ch1, ch0}; g5 = 2'b00; sel5 = 3'd7; scan5 = 1'b1;
    tick(1'b1, 2'b00, 3'd7, 1'b0, "scan5_entry_oor");
    for (int i = 0; i < 25; i++) begin
      int p;
      p = (i / 3) % 5;
      tick(1'b1, {ch1[p], ch0[p]}, 3'(p), i % 15 == 14, $sformatf("scan5_%0d", i));
    end
    rst_n = 1'b0;
    #1;
    expect_now(1'b1, 2'b00, 3'd0, 1'b0, "reset_mid_scan");
    for (int i = 0; i < 6; i++)
      tick(1'b1, 2'b00, 3'd0, 1'b0, "reset_mid_hold");
    scan5 = 1'b0; sel5 = 3'd5;
    rst_n = 1'b1;
    tick(1'b1, 2'b00, 3'd5, 1'b0, "oor5");
    sel5 = 3'd6;
    tick(1'b1, 2'b00, 3'd6, 1'b0, "oor6");
    sel5 = 3'd4;
    tick(1'b1, 2'b01, 3'd4, 1'b0, "direct5_sel4");
    scan5 = 1'b1;
    tick(1'b1, 2'b01, 3'd4, 1'b0, "reentry5_sel");
    for (int i = 0; i < 3; i++)
      tick(1'b1, 2'b10, 3'd0, 1'b0, "reentry5_pos0");
    g5 = 2'b10;
    tick(1'b1, 2'b01, 3'd1, 1'b0, "reentry5_pos1_g");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
